// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI responder: opcodes, byte-level FSM states
// and the RGB565 colours the LCD driver also uses.
package lcd_spi_pkg;

    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC = 8'h3C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_WR_HI,
        S_WR_LO
    } rx_state_e;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

    function automatic logic [3:0] idx_inc_sat(input logic [3:0] idx);
        return (idx == 4'hF) ? idx : idx + 4'd1;
    endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// SPI wires from the LCD driver plus the decoded command/parameter/pixel outputs.
interface lcd_spi_rx_if #(
    parameter int COORD_W = 9
);
    logic               lcd_cs_in;
    logic               lcd_clk_in;
    logic               lcd_data_in;
    logic               lcd_dc_in;

    logic               cmd_valid;
    logic [7:0]         cmd_byte;
    logic               param_valid;
    logic [7:0]         param_byte;
    logic [3:0]         param_idx;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [15:0]        pix_data;
    logic               frame_done;

    modport master (
        output lcd_cs_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
        input  cmd_valid, cmd_byte, param_valid, param_byte, param_idx,
        input  pix_valid, pix_x, pix_y, pix_data, frame_done
    );

    modport slave (
        input  lcd_cs_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
        output cmd_valid, cmd_byte, param_valid, param_byte, param_idx,
        output pix_valid, pix_x, pix_y, pix_data, frame_done
    );
endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Synchronises the SPI wires into clk_i, detects SCLK rising edges and
// assembles MSB-first bytes framed by chip select.
module lcd_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       dc_i,
    output logic       byte_rdy_o,
    output logic [7:0] byte_o,
    output logic       dc_o
);
    // Each entry is {cs, sclk, mosi, dc}; all four share one delay so they stay aligned.
    logic [3:0] sync_q [SYNC_STAGES];
    logic       sclk_prev_q;
    logic [6:0] shift_q;
    logic [2:0] cnt_q;
    logic       rdy_q;
    logic [7:0] byte_q;
    logic       dc_q;

    logic cs_s, sclk_s, mosi_s, dc_s, rise;

    assign {cs_s, sclk_s, mosi_s, dc_s} = sync_q[SYNC_STAGES-1];
    assign rise = sclk_s & ~sclk_prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1000;
            sclk_prev_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            byte_q      <= '0;
            dc_q        <= 1'b0;
        end else begin
            sync_q[0] <= {cs_i, sclk_i, mosi_i, dc_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= sclk_s;
            rdy_q       <= 1'b0;
            if (cs_s) begin
                cnt_q <= '0;
            end else if (rise) begin
                shift_q <= {shift_q[5:0], mosi_s};
                cnt_q   <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    byte_q <= {shift_q, mosi_s};
                    dc_q   <= dc_s;
                    rdy_q  <= 1'b1;
                end
            end
        end
    end

    assign byte_rdy_o = rdy_q;
    assign byte_o     = byte_q;
    assign dc_o       = dc_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// ST7789-style panel model: decodes commands/parameters, tracks the CASET/RASET
// window and emits one strobe per RGB565 pixel with its coordinate.
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int LCD_W       = 240,
    parameter int LCD_H       = 240,
    parameter int COORD_W     = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    lcd_spi_rx_if.slave  bus
);
    localparam logic [15:0] XE_RST = 16'(LCD_W - 1);
    localparam logic [15:0] YE_RST = 16'(LCD_H - 1);

    logic       rx_rdy;
    logic [7:0] rx_byte;
    logic       rx_dc;

    lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk_i      (clk_in),
        .rst_n_i    (rst_n_in),
        .cs_i       (bus.lcd_cs_in),
        .sclk_i     (bus.lcd_clk_in),
        .mosi_i     (bus.lcd_data_in),
        .dc_i       (bus.lcd_dc_in),
        .byte_rdy_o (rx_rdy),
        .byte_o     (rx_byte),
        .dc_o       (rx_dc)
    );

    rx_state_e          state_q, state_d;
    logic [15:0]        xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    logic [7:0]         hi_q, hi_d;
    logic [3:0]         idx_q, idx_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;
    logic               param_valid_q, param_valid_d;
    logic [7:0]         param_byte_q, param_byte_d;
    logic [3:0]         param_idx_q, param_idx_d;
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic               frame_done_q, frame_done_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            xs_q          <= '0;
            xe_q          <= XE_RST;
            ys_q          <= '0;
            ye_q          <= YE_RST;
            x_q           <= '0;
            y_q           <= '0;
            hi_q          <= '0;
            idx_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= '0;
            param_valid_q <= 1'b0;
            param_byte_q  <= '0;
            param_idx_q   <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hi_q          <= hi_d;
            idx_q         <= idx_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_byte_q    <= cmd_byte_d;
            param_valid_q <= param_valid_d;
            param_byte_q  <= param_byte_d;
            param_idx_q   <= param_idx_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        x_d           = x_q;
        y_d           = y_q;
        hi_d          = hi_q;
        idx_d         = idx_q;
        cmd_valid_d   = 1'b0;
        cmd_byte_d    = cmd_byte_q;
        param_valid_d = 1'b0;
        param_byte_d  = param_byte_q;
        param_idx_d   = param_idx_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        frame_done_d  = 1'b0;

        if (rx_rdy) begin
            if (!rx_dc) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = rx_byte;
                idx_d       = '0;
                case (rx_byte)
                    CMD_CASET:  state_d = S_CASET;
                    CMD_RASET:  state_d = S_RASET;
                    CMD_RAMWR: begin
                        state_d = S_WR_HI;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    CMD_RAMWRC: state_d = S_WR_HI;
                    default:    state_d = S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_WR_HI: begin
                        hi_d    = rx_byte;
                        state_d = S_WR_LO;
                    end
                    S_WR_LO: begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_q, rx_byte};
                        pix_x_d     = x_q[COORD_W-1:0];
                        pix_y_d     = y_q[COORD_W-1:0];
                        // Equality (not magnitude) compare lets a window with XS>XE run through the 16-bit wrap.
                        if (x_q == xe_q) begin
                            x_d = xs_q;
                            if (y_q == ye_q) begin
                                y_d          = ys_q;
                                frame_done_d = 1'b1;
                            end else begin
                                y_d = y_q + 16'd1;
                            end
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                        state_d = S_WR_HI;
                    end
                    default: begin
                        param_valid_d = 1'b1;
                        param_byte_d  = rx_byte;
                        param_idx_d   = idx_q;
                        idx_d         = idx_inc_sat(idx_q);
                        if (state_q == S_CASET) begin
                            case (idx_q)
                                4'd0:    xs_d[15:8] = rx_byte;
                                4'd1:    xs_d[7:0]  = rx_byte;
                                4'd2:    xe_d[15:8] = rx_byte;
                                4'd3:    xe_d[7:0]  = rx_byte;
                                default: ;
                            endcase
                        end else if (state_q == S_RASET) begin
                            case (idx_q)
                                4'd0:    ys_d[15:8] = rx_byte;
                                4'd1:    ys_d[7:0]  = rx_byte;
                                4'd2:    ye_d[15:8] = rx_byte;
                                4'd3:    ye_d[7:0]  = rx_byte;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_byte    = cmd_byte_q;
    assign bus.param_valid = param_valid_q;
    assign bus.param_byte  = param_byte_q;
    assign bus.param_idx   = param_idx_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_data    = pix_data_q;
    assign bus.frame_done  = frame_done_q;

endmodule
